// File: rtl/instr_buffer.sv
// instr_buffer: circular instruction FIFO between fetch and dispatch.
// Accepts up to FETCH_WIDTH instructions per cycle in program order and
// presents the DISPATCH_WIDTH oldest entries to dispatch every cycle.
// Each entry carries a 32-bit PC and a 32-bit instruction word.
module instr_buffer #(
    parameter int IB_DEPTH       = 16,
    parameter int FETCH_WIDTH    = 4,
    parameter int DISPATCH_WIDTH = 3
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [FETCH_WIDTH-1:0]                fetch_valid,
    input  logic [FETCH_WIDTH-1:0][31:0]          fetch_pc,
    input  logic [FETCH_WIDTH-1:0][31:0]          fetch_inst,
    output logic [$clog2(IB_DEPTH+1)-1:0]         ib_free_slots,
    input  logic                                  flush,
    output logic [DISPATCH_WIDTH-1:0]             dispatch_valid,
    output logic [DISPATCH_WIDTH-1:0][31:0]       dispatch_pc,
    output logic [DISPATCH_WIDTH-1:0][31:0]       dispatch_inst,
    input  logic [1:0]                            dispatch_count,
    output logic                                  overflow_err
);

    localparam int PTR_BITS    = $clog2(IB_DEPTH);
    localparam int IB_IDX_BITS = $clog2(IB_DEPTH + 1);
    localparam int CNT_BITS    = $clog2(FETCH_WIDTH + 1);

    logic [31:0]            pc_mem   [IB_DEPTH];
    logic [31:0]            inst_mem [IB_DEPTH];
    logic [PTR_BITS-1:0]    head;
    logic [PTR_BITS-1:0]    tail;
    logic [IB_IDX_BITS-1:0] count;

    logic [CNT_BITS-1:0]    n_in;
    logic [IB_IDX_BITS-1:0] n_out;
    logic [IB_IDX_BITS-1:0] n_enq;
    logic                   enq_legal;

    // Free slots come from registered occupancy only, ignoring same-cycle dequeue.
    assign ib_free_slots = IB_IDX_BITS'(IB_DEPTH) - count;

    // Count live fetch lanes, clamp the dequeue request and judge enqueue legality.
    always_comb begin
        n_in = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            n_in = n_in + CNT_BITS'(fetch_valid[k]);
        end
        n_out     = (IB_IDX_BITS'(dispatch_count) < count) ? IB_IDX_BITS'(dispatch_count) : count;
        enq_legal = (IB_IDX_BITS'(n_in) <= ib_free_slots);
        n_enq     = enq_legal ? IB_IDX_BITS'(n_in) : '0;
    end

    // Pointer, occupancy and overflow-pulse registers; flush empties the buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            head         <= head + PTR_BITS'(n_out);
            tail         <= tail + PTR_BITS'(n_enq);
            count        <= count + n_enq - n_out;
            overflow_err <= ~enq_legal;
        end
    end

    // Entry array writes; storage needs no reset because invalid lanes are masked.
    always_ff @(posedge clock) begin
        if (!flush && enq_legal) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (CNT_BITS'(k) < n_in) begin
                    pc_mem[tail + PTR_BITS'(k)]   <= fetch_pc[k];
                    inst_mem[tail + PTR_BITS'(k)] <= fetch_inst[k];
                end
            end
        end
    end

    // Present the oldest entries to dispatch, driving zero on lanes past occupancy.
    always_comb begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            dispatch_valid[i] = (IB_IDX_BITS'(i) < count);
            dispatch_pc[i]    = dispatch_valid[i] ? pc_mem[head + PTR_BITS'(i)]   : 32'h0;
            dispatch_inst[i]  = dispatch_valid[i] ? inst_mem[head + PTR_BITS'(i)] : 32'h0;
        end
    end

endmodule
